// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: opcodes, flag bit positions, FSM encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_CMP = 4'b1100;
    localparam logic [3:0] OP_PSA = 4'b1101;
    localparam logic [3:0] OP_PSB = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam int unsigned FLAG_W        = 8;
    localparam int unsigned FLAG_ZERO     = 0;
    localparam int unsigned FLAG_CARRY    = 1;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_SIGN     = 3;
    localparam int unsigned FLAG_PARITY   = 4;
    localparam int unsigned FLAG_GT       = 5;
    localparam int unsigned FLAG_LT       = 6;
    localparam int unsigned FLAG_EQ       = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Width of one buffered request {opcode, a, b}.
    function automatic int unsigned req_width(int unsigned n);
        return 4 + 2 * n;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response channels of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned N = 8
) ();
    import alu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_opcode;
    logic [N-1:0]      req_a;
    logic [N-1:0]      req_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_opcode;
    logic [N-1:0]      rsp_out;
    logic [FLAG_W-1:0] rsp_flags;

    // Command source / result consumer side.
    modport master (
        output req_valid, req_opcode, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_opcode, rsp_out, rsp_flags,
        output rsp_ready
    );

    // Controller side.
    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_opcode, rsp_out, rsp_flags,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; extra pointer MSB distinguishes full from empty.
module alu_req_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop never frees space for a push in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencing front-end for an external combinational ALU: queue, drive, settle, capture.
// Optional build macro ALU_ISSUE_STICKY_FLAGS_EN adds sticky overflow/carry flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        alu_opcode_o,
    output logic [N-1:0]      alu_a_o,
    output logic [N-1:0]      alu_b_o,
    input  logic [N-1:0]      alu_out_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  op_count_o
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    ,
    input  logic              sticky_clr_i,
    output logic [1:0]        sticky_flags_o
`endif
);
    localparam int unsigned REQ_W     = req_width(N);
    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

    logic [REQ_W-1:0] head;
    logic             full, empty, pop;
    logic [3:0]       head_op;
    logic [N-1:0]     head_a, head_b;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [N-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [3:0]        rsp_op_q, rsp_op_d;
    logic [N-1:0]      rsp_out_q, rsp_out_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              capture, handshake, dispatch;

    alu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.req_valid),
        .wdata_i ({bus.req_opcode, bus.req_a, bus.req_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_op = head[REQ_W-1 -: 4];
    assign head_a  = head[2*N-1:N];
    assign head_b  = head[N-1:0];

    assign handshake = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;
        capture     = 1'b0;
        dispatch    = 1'b0;

        unique case (state_q)
            ST_IDLE: dispatch = 1'b1;
            ST_EXEC: begin
                if (cnt_q == SETTLE_M1) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: dispatch = handshake;
            default: state_d = ST_IDLE;
        endcase

        // NOPs are dropped here and never reach the ALU or the response path.
        if (dispatch) begin
            if (empty) begin
                state_d = ST_IDLE;
            end else begin
                pop = 1'b1;
                if (head_op == OP_NOP) begin
                    state_d = ST_IDLE;
                end else begin
                    alu_op_d = head_op;
                    alu_a_d  = head_a;
                    alu_b_d  = head_b;
                    cnt_d    = 4'd0;
                    state_d  = ST_EXEC;
                end
            end
        end

        if (handshake) begin
            rsp_valid_d = 1'b0;
            op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_op_d    = alu_op_q;
            rsp_out_d   = alu_out_i;
            rsp_flags_d = alu_flags_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_op_q    <= OP_NOP;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.req_ready  = !full;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_opcode = rsp_op_q;
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign alu_opcode_o   = alu_op_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign op_count_o     = op_count_q;
    assign busy_o         = (state_q != ST_IDLE) || !empty;

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    // Clear first so a same-cycle capture still lands its flags.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr_i) sticky_d = 2'b00;
        if (capture) sticky_d = sticky_d | {alu_flags_i[FLAG_OVERFLOW], alu_flags_i[FLAG_CARRY]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= 2'b00;
        else     sticky_q <= sticky_d;
    end

    assign sticky_flags_o = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stand-in and reference model.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned N      = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [3:0]        op;
        logic [N-1:0]      out;
        logic [FLAG_W-1:0] flags;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.N(N)) bus ();

    logic [3:0]        alu_opcode;
    logic [N-1:0]      alu_a, alu_b, alu_out;
    logic [FLAG_W-1:0] alu_flags;
    logic              busy;
    logic [CNT_W-1:0]  op_count;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    logic              sticky_clr = 1'b0;
    logic [1:0]        sticky_flags;
`endif

    alu_issue_ctrl #(
        .N      (N),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_opcode_o (alu_opcode),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_out_i    (alu_out),
        .alu_flags_i  (alu_flags),
        .busy_o       (busy),
        .op_count_o   (op_count)
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        ,
        .sticky_clr_i   (sticky_clr),
        .sticky_flags_o (sticky_flags)
`endif
    );

    // Behavioural ALU: result and flags from plain arithmetic on the operands.
    function automatic rsp_t alu_ref(logic [3:0] op, logic [N-1:0] a, logic [N-1:0] b);
        logic [N:0]        w;
        logic [N-1:0]      r;
        logic              c, v;
        logic [FLAG_W-1:0] f;
        rsp_t              res;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[N-1:0];
                c = w[N];
                v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[N-1:0];
                c = w[N];
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_INC: r = a + 1;
            OP_DEC: r = a - 1;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin r = a << 1; c = a[N-1]; end
            OP_SHR: begin r = a >> 1; c = a[0]; end
            OP_PSB: r = b;
            OP_NOP: r = '0;
            default: r = a;
        endcase
        f = '0;
        f[FLAG_ZERO]     = (r == 0);
        f[FLAG_CARRY]    = c;
        f[FLAG_OVERFLOW] = v;
        f[FLAG_SIGN]     = r[N-1];
        f[FLAG_PARITY]   = ^r;
        f[FLAG_GT]       = (a > b);
        f[FLAG_LT]       = (a < b);
        f[FLAG_EQ]       = (a == b);
        res.op    = op;
        res.out   = r;
        res.flags = f;
        return res;
    endfunction

    rsp_t alu_now;
    assign alu_now   = alu_ref(alu_opcode, alu_a, alu_b);
    assign alu_out   = alu_now.out;
    assign alu_flags = alu_now.flags;

    int   vectors    = 0;
    int   miscompares = 0;
    int   hs_cnt     = 0;
    rsp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: compare every handshaken response against the scoreboard head.
    initial begin
        rsp_t cur, held, exp;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus.rsp_valid) begin
                stall_prev = 1'b0;
            end else begin
                cur = {bus.rsp_opcode, bus.rsp_out, bus.rsp_flags};
                if (stall_prev) check("rsp_stable", 32'(cur), 32'(held));
                if (bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        note_fail("unexpected_rsp");
                    end else begin
                        exp = sb.pop_front();
                        check("rsp_opcode", 32'(cur.op), 32'(exp.op));
                        check("rsp_out", 32'(cur.out), 32'(exp.out));
                        check("rsp_flags", 32'(cur.flags), 32'(exp.flags));
                        check("op_count", 32'(op_count), 32'(hs_cnt[CNT_W-1:0]));
                        hs_cnt++;
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    held = cur;
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(logic [3:0] op, logic [N-1:0] a, logic [N-1:0] b);
        int t;
        t = 0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        @(negedge clk);
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) note_fail("req_timeout");
        else if (op != OP_NOP) sb.push_back(alu_ref(op, a, b));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while ((sb.size() != 0 || busy) && t < 1000);
        if (sb.size() != 0 || busy) note_fail("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic             rnd_done;
    logic [CNT_W-1:0] base, tgt;
    int               k;
    logic             any;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        rnd_done       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_alu_opcode", 32'(alu_opcode), 32'(OP_NOP));
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_out", 32'(bus.rsp_out), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(bus.req_ready), 1);

        // Idle latency: accept E0, ALU drive after E1, capture SETTLE edges later.
        @(posedge clk);
        #1;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_ADD;
        bus.req_a      = 8'h0A;
        bus.req_b      = 8'h05;
        sb.push_back(alu_ref(OP_ADD, 8'h0A, 8'h05));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("lat_alu_opcode", 32'(alu_opcode), 32'(OP_ADD));
        check("lat_alu_a", 32'(alu_a), 32'h0A);
        check("lat_alu_b", 32'(alu_b), 32'h05);
        k = 1;
        while (!bus.rsp_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rsp_latency", k, SETTLE + 1);
        @(posedge clk);
        #1;
        check("op_count_first", 32'(op_count), 1);

        // Backpressure: one op parked in RESP plus a full FIFO.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom));
        check("req_ready_full", 32'(bus.req_ready), 0);
        repeat (6) @(posedge clk);
        #1;
        check("req_ready_held", 32'(bus.req_ready), 0);
        base = op_count;
        tgt = base + 5;
        bus.rsp_ready = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (op_count != tgt && k < 100);
        check("throughput", k, 1 + 4 * (SETTLE + 1));
        drain();

        send(OP_SUB, 8'h72, 8'h93);
        drain();

        base = op_count;
        send(OP_NOP, 8'h11, 8'h22);
        send(OP_AND, 8'hB2, 8'h03);
        drain();
        tgt = base + 1;
        check("nop_single_rsp", 32'(op_count), 32'(tgt));
        send(OP_NOP, 8'h33, 8'h44);
        drain();
        check("nop_no_drive", 32'(alu_opcode), 32'(OP_AND));

        // Randomised traffic with random consumer stalls; op_count wraps here.
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(($urandom_range(0, 9) == 0) ? OP_NOP : 4'($urandom_range(0, 14)),
                         8'($urandom), 8'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        drain();

        // Reset while executing with two ops queued.
        send(OP_ADD, 8'h01, 8'h02);
        send(OP_SUB, 8'h05, 8'h03);
        send(OP_XOR, 8'hF0, 8'h0F);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_alu_opcode", 32'(alu_opcode), 32'(OP_NOP));
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mid_rst_rsp_flags", 32'(bus.rsp_flags), 0);
        check("mid_rst_op_count", 32'(op_count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        sb.delete();
        hs_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        any = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any = any | bus.rsp_valid;
        end
        check("post_rst_no_rsp", 32'(any), 0);
        check("post_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        send(OP_ADD, 8'hFF, 8'h01);
        drain();
        check("sticky_set", 32'(sticky_flags[0]), 1);
        send(OP_ADD, 8'h01, 8'h01);
        drain();
        check("sticky_hold", 32'(sticky_flags[0]), 1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        check("sticky_clr", 32'(sticky_flags), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing front-end for the combinational `alu`.
- Buffers operation requests {opcode, a, b} in a small FIFO.
- Drives the ALU operand/opcode ports from registers and waits a programmable settle time.
- Captures `out` plus all eight flags into a response register, presented on a valid/ready interface.
- Sits between the command source (CDC synchronizer output / test sequencer) and the result consumer; the ALU instance lives outside this block.

Parameters:
- N, 8, operand/result width; matches the `alu` N.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- SETTLE, 1, cycles alu_* are held before capture; 1..15.
- CNT_W, 16, width of op_count.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_opcode  in  4  ALU opcode.
- req_a  in  N  operand a.
- req_b  in  N  operand b.
- alu_opcode  out  4  to alu.opcode, registered.
- alu_a  out  N  to alu.a, registered.
- alu_b  out  N  to alu.b, registered.
- alu_out  in  N  from alu.out.
- alu_flags  in  8  {eq,lt,gt,parity,sign,overflow,carry,zero}, bit0=zero.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_opcode  out  4  opcode of the response.
- rsp_out  out  N  captured result.
- rsp_flags  out  8  captured flags.
- busy  out  1  state!=IDLE or FIFO non-empty.
- op_count  out  CNT_W  completed (handshaken) responses, wraps.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty.
  - State IDLE.
  - All outputs 0: alu_opcode=4'b1111 (NOP), rsp_*=0, op_count=0, busy=0.
  - req_ready=1 after release.
- Push: req_valid&&req_ready at an edge writes the FIFO.
  - req_ready = !full.
  - No full-bypass: a pop in the same cycle does not make room that cycle.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head opcode==4'b1111 (NOP): pop and discard; no ALU drive, no response, stay in IDLE.
  - Otherwise: pop, load alu_* from head, clear settle counter, go EXEC.
- EXEC:
  - Counter increments each cycle.
  - When counter==SETTLE-1: capture alu_out/alu_flags/alu_opcode into rsp_*, set rsp_valid=1, go RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: op_count+=1; rsp_valid=0 unless a new capture occurs.
  - Next state as in IDLE: pop next non-NOP and go EXEC, discard a NOP and go IDLE, or go IDLE if empty.
  - rsp_out/rsp_flags keep their last value after the handshake.
- alu_* hold their last value between operations.
- Latency, idle block, SETTLE=1: accept edge E0 → alu_* valid after E1 → rsp_valid=1 after E2.
- Throughput with rsp_ready=1: one result every SETTLE+1 cycles.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight and queued requests are dropped, no response is produced, outputs return to reset values.

Optional Feature:
- Macro: ALU_ISSUE_STICKY_FLAGS_EN.
- Defined:
  - Adds ports sticky_clr (in, 1) and sticky_flags (out, 2) = {overflow, carry}.
  - Each capture ORs the captured overflow/carry into sticky_flags.
  - sticky_clr clears it; a capture in the same cycle has priority (flags from that capture set).
  - Reset value 0.
- Undefined: these ports and the register do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - Opcode constants for ADD..NOP (4'b0000..4'b1111).
  - Flag bit index constants and FLAG_W=8.
  - State enum {IDLE, EXEC, RESP}.
- Sub-module alu_req_fifo: synchronous FIFO, DEPTH×(4+2N), push/pop/full/empty; ptr width clog2(DEPTH)+1.

Test Plan:
- ADD a=0x0A b=0x05, rsp_ready=1 → alu_* loaded after E1; rsp_valid after E2; rsp_out=0x0F, zero=0; op_count=1.
- Hold rsp_ready=0, push 4 requests while one op sits in RESP → req_ready=0 once the FIFO holds 4; rsp_* stable; releasing rsp_ready yields all 5 results in order.
- SUB a=0x72 b=0x93 with SETTLE=3 → capture exactly 3 cycles after load; rsp_out=0xDF; sign=1.
- Push NOP, then AND a=0xB2 b=0x03 → single response: opcode 4'b0100, rsp_out=0x02; op_count increments by 1.
- Assert rst while in EXEC with 2 queued ops → all outputs 0 asynchronously, alu_opcode=4'b1111; no responses after release; busy=0.
- With ALU_ISSUE_STICKY_FLAGS_EN: ADD 0xFF+0x01 (carry), then ADD 0x01+0x01 → sticky_flags[0] stays 1 until sticky_clr.
